// File: rtl/bp_cfg_link_pkg.sv
// Shared cfg-link constants and types: register map, loader states, cfg bus payload, proc configs.
package bp_cfg_link_pkg;

    localparam int CFG_CORE_WIDTH  = 8;
    localparam int CFG_ADDR_WIDTH  = 16;
    localparam int CFG_DATA_WIDTH  = 64;
    localparam int CCE_PC_WIDTH    = 8;
    localparam int CCE_INSTR_WIDTH = 48;
    localparam int CCE_UCODE_ELS   = 256;

    localparam logic [CFG_ADDR_WIDTH-1:0] CFG_FREEZE_ADDR = 16'h0001;
    localparam logic [CFG_ADDR_WIDTH-1:0] CFG_UCODE_BASE  = 16'h8000;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg,
        e_bp_dual_core_cfg
    } bp_params_e;

    typedef enum logic [2:0] {
        e_idle,
        e_freeze,
        e_fetch,
        e_write,
        e_unfreeze,
        e_done
    } bp_cfg_loader_state_e;

    typedef struct packed {
        logic [CFG_CORE_WIDTH-1:0] core;
        logic [CFG_ADDR_WIDTH-1:0] addr;
        logic [CFG_DATA_WIDTH-1:0] data;
    } bp_cfg_bus_s;

    function automatic int cfg_num_core(bp_params_e cfg);
        return (cfg == e_bp_dual_core_cfg) ? 2 : 1;
    endfunction

endpackage

// File: rtl/bp_cfg_ucode_loader_if.sv
// Loader-side bundle: synchronous ucode ROM read port plus the valid/ready cfg write bus.
interface bp_cfg_ucode_loader_if #(
    parameter int cfg_core_width_p  = 8,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int cce_pc_width_p    = 8,
    parameter int cce_instr_width_p = 48
);
    logic                         ucode_r_v_o;
    logic [cce_pc_width_p-1:0]    ucode_addr_o;
    logic [cce_instr_width_p-1:0] ucode_data_i;

    logic                         cfg_v_o;
    logic [cfg_core_width_p-1:0]  cfg_core_o;
    logic [cfg_addr_width_p-1:0]  cfg_addr_o;
    logic [cfg_data_width_p-1:0]  cfg_data_o;
    logic                         cfg_ready_i;

    modport master (
        output ucode_r_v_o, ucode_addr_o,
        input  ucode_data_i,
        output cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o,
        input  cfg_ready_i
    );

    modport slave (
        input  ucode_r_v_o, ucode_addr_o,
        output ucode_data_i,
        input  cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o,
        output cfg_ready_i
    );
endinterface

// File: rtl/bp_cfg_ucode_loader.sv
// Boot sequencer: freeze every core, stream CCE ucode from ROM into each core, unfreeze every core.
// Latency: first cfg write the cycle after start_i; ucode writes take fetch+write (2 cycles min).
// Backpressure: cfg payload is held stable while cfg_v_o & !cfg_ready_i; nothing advances without a transfer.
module bp_cfg_ucode_loader
    import bp_cfg_link_pkg::*;
#(
    parameter bp_params_e bp_params_p       = e_bp_single_core_cfg,
    parameter int         num_core_p        = cfg_num_core(bp_params_p),
    parameter int         cfg_core_width_p  = CFG_CORE_WIDTH,
    parameter int         cfg_addr_width_p  = CFG_ADDR_WIDTH,
    parameter int         cfg_data_width_p  = CFG_DATA_WIDTH,
    parameter int         cce_pc_width_p    = CCE_PC_WIDTH,
    parameter int         cce_instr_width_p = CCE_INSTR_WIDTH,
    parameter int         ucode_els_p       = CCE_UCODE_ELS,
    parameter bit         skip_ucode_p      = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    bp_cfg_ucode_loader_if.master   ldr_if,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int CORE_CNT_W = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam logic [CORE_CNT_W-1:0]     CORE_LAST = CORE_CNT_W'(num_core_p - 1);
    localparam logic [cce_pc_width_p-1:0] PC_LAST   = cce_pc_width_p'(ucode_els_p - 1);

    if (cfg_core_width_p != CFG_CORE_WIDTH || cfg_addr_width_p != CFG_ADDR_WIDTH ||
        cfg_data_width_p != CFG_DATA_WIDTH) begin : g_bad_bus_width
        $error("cfg bus widths must match bp_cfg_bus_s");
    end
    if (cce_instr_width_p > cfg_data_width_p) begin : g_bad_instr_width
        $error("cce_instr_width_p must not exceed cfg_data_width_p");
    end
    if (ucode_els_p < 1 || ucode_els_p > (1 << cce_pc_width_p)) begin : g_bad_ucode_els
        $error("ucode_els_p out of range for cce_pc_width_p");
    end

    bp_cfg_loader_state_e           state_q, state_d;
    logic [CORE_CNT_W-1:0]          core_cnt_q, core_cnt_d;
    logic [cce_pc_width_p-1:0]      pc_cnt_q, pc_cnt_d;
    logic                           done_q, done_d;
    logic                           rd_q, rd_d;
    logic [CFG_DATA_WIDTH-1:0]      hold_q, hold_d;
    logic [CFG_DATA_WIDTH-1:0]      rom_word;
    logic                           cfg_v, xfer, core_last, pc_last;
    bp_cfg_bus_s                    bus;

    assign rom_word  = CFG_DATA_WIDTH'(ldr_if.ucode_data_i);
    assign cfg_v     = (state_q == e_freeze) || (state_q == e_write) || (state_q == e_unfreeze);
    assign xfer      = cfg_v && ldr_if.cfg_ready_i;
    assign core_last = (core_cnt_q == CORE_LAST);
    assign pc_last   = (pc_cnt_q == PC_LAST);

    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        pc_cnt_d   = pc_cnt_q;
        done_d     = done_q;
        rd_d       = (state_q == e_fetch);
        // ROM data is only valid the cycle after the read, so capture it then
        hold_d     = rd_q ? rom_word : hold_q;
        unique case (state_q)
            e_idle, e_done: begin
                if (start_i) begin
                    state_d    = e_freeze;
                    core_cnt_d = '0;
                    pc_cnt_d   = '0;
                    done_d     = 1'b0;
                end
            end
            e_freeze: begin
                if (xfer) begin
                    if (core_last) begin
                        core_cnt_d = '0;
                        state_d    = skip_ucode_p ? e_unfreeze : e_fetch;
                    end else begin
                        core_cnt_d = core_cnt_q + CORE_CNT_W'(1);
                    end
                end
            end
            e_fetch: state_d = e_write;
            e_write: begin
                if (xfer) begin
                    state_d = e_fetch;
                    if (!pc_last) begin
                        pc_cnt_d = pc_cnt_q + cce_pc_width_p'(1);
                    end else begin
                        pc_cnt_d = '0;
                        if (core_last) begin
                            core_cnt_d = '0;
                            state_d    = e_unfreeze;
                        end else begin
                            core_cnt_d = core_cnt_q + CORE_CNT_W'(1);
                        end
                    end
                end
            end
            e_unfreeze: begin
                if (xfer) begin
                    if (core_last) begin
                        core_cnt_d = '0;
                        state_d    = e_done;
                        done_d     = 1'b1;
                    end else begin
                        core_cnt_d = core_cnt_q + CORE_CNT_W'(1);
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        bus = '0;
        unique case (state_q)
            e_freeze, e_unfreeze: begin
                bus.core = CFG_CORE_WIDTH'(core_cnt_q);
                bus.addr = CFG_FREEZE_ADDR;
                bus.data = (state_q == e_freeze) ? CFG_DATA_WIDTH'(1) : '0;
            end
            e_write: begin
                bus.core = CFG_CORE_WIDTH'(core_cnt_q);
                bus.addr = CFG_UCODE_BASE + CFG_ADDR_WIDTH'(pc_cnt_q);
                bus.data = rd_q ? rom_word : hold_q;
            end
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            core_cnt_q <= '0;
            pc_cnt_q   <= '0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            core_cnt_q <= core_cnt_d;
            pc_cnt_q   <= pc_cnt_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            hold_q     <= hold_d;
        end
    end

    assign ldr_if.ucode_r_v_o  = (state_q == e_fetch);
    assign ldr_if.ucode_addr_o = (state_q == e_fetch) ? pc_cnt_q : '0;
    assign ldr_if.cfg_v_o      = cfg_v;
    assign ldr_if.cfg_core_o   = bus.core;
    assign ldr_if.cfg_addr_o   = bus.addr;
    assign ldr_if.cfg_data_o   = bus.data;
    assign busy_o              = (state_q != e_idle) && (state_q != e_done);
    assign done_o              = done_q;

endmodule
